// File: rtl/program_counter_unit.sv
// Program counter unit: next-address selection, wait-for-input handshake
// with a synchronized confirm switch, halt state, and a saturating count
// of retired instructions.
module program_counter_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_ADDR = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            muxPC,
    input  logic                  branchTaken,
    input  logic [ADDR_WIDTH-1:0] targetAddr,
    input  logic                  inputConfirm,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  waitingInput,
    output logic                  inputCommit,
    output logic [15:0]           retiredCount
);

    localparam logic [3:0] SEL_BRANCH = 4'd2;
    localparam logic [3:0] SEL_JUMP   = 4'd3;
    localparam logic [3:0] SEL_HALT   = 4'd4;
    localparam logic [3:0] SEL_WAIT   = 4'd5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_IN = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg, pc_next, pc_inc;
    logic [15:0]             count_reg, count_next;
    logic                    s1_reg, s2_reg, s3_reg;
    logic                    confirm_edge;
    logic                    retire;
    logic                    commit;

    // Wraps naturally at the top of the address space.
    assign pc_inc       = pc_reg + ADDR_WIDTH'(1);
    // A rising edge seen after synchronization; a level that is already
    // high produces no edge, so only a fresh press can commit.
    assign confirm_edge = s2_reg & ~s3_reg;

    // Synchronizer chain for the asynchronous confirm switch plus edge flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= inputConfirm;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // State, pc and retired-instruction counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            pc_reg    <= ADDR_WIDTH'(RESET_ADDR);
            count_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
        end
    end

    // Next-state, next-pc and commit strobe decode.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        retire     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            RUN: begin
                case (muxPC)
                    SEL_BRANCH: begin
                        pc_next = branchTaken ? targetAddr : pc_inc;
                        retire  = 1'b1;
                    end
                    SEL_JUMP: begin
                        pc_next = targetAddr;
                        retire  = 1'b1;
                    end
                    SEL_HALT: state_next = HALT;
                    SEL_WAIT: state_next = WAIT_IN;
                    // Code 1 and every undefined code simply advance.
                    default: begin
                        pc_next = pc_inc;
                        retire  = 1'b1;
                    end
                endcase
            end
            WAIT_IN: begin
                if (confirm_edge) begin
                    commit     = 1'b1;
                    pc_next    = pc_inc;
                    state_next = RUN;
                    retire     = 1'b1;
                end
            end
            HALT: state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // Saturating increment of the retired count.
    always_comb begin
        count_next = count_reg;
        if (retire && (count_reg != 16'hFFFF)) begin
            count_next = count_reg + 16'd1;
        end
    end

    assign pc           = pc_reg;
    assign retiredCount = count_reg;
    assign inputCommit  = commit;
    assign halted       = (state_reg == HALT);
    assign waitingInput = (state_reg == WAIT_IN);

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit: sequential run, wrap, branch,
// jump, wait-for-input handshake, halt, asynchronous reset and saturation.
module tb_program_counter_unit;

    logic        clock;
    logic        reset;
    logic [3:0]  muxPC;
    logic        branchTaken;
    logic [9:0]  targetAddr;
    logic        inputConfirm;
    logic [9:0]  pc;
    logic        halted;
    logic        waitingInput;
    logic        inputCommit;
    logic [15:0] retiredCount;

    int total = 0;
    int bad   = 0;

    program_counter_unit #(.ADDR_WIDTH(10), .RESET_ADDR(0)) dut (
        .clock        (clock),
        .reset        (reset),
        .muxPC        (muxPC),
        .branchTaken  (branchTaken),
        .targetAddr   (targetAddr),
        .inputConfirm (inputConfirm),
        .pc           (pc),
        .halted       (halted),
        .waitingInput (waitingInput),
        .inputCommit  (inputCommit),
        .retiredCount (retiredCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        muxPC = 4'd1; branchTaken = 1'b0; targetAddr = 10'd0; inputConfirm = 1'b0;
        reset = 1'b0;
        #3;
        total++; if (pc !== 10'd0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 10'd0); end
        total++; if (retiredCount !== 16'd0) begin bad++; $display("FAIL reset_count got=%h exp=0", retiredCount); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (waitingInput !== 1'b0) begin bad++; $display("FAIL reset_waiting got=%b exp=0", waitingInput); end
        total++; if (inputCommit !== 1'b0) begin bad++; $display("FAIL reset_commit got=%b exp=0", inputCommit); end
        tick();
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        do_reset();
        muxPC = 4'd1;
        total++; if (pc !== 10'd0) begin bad++; $display("FAIL seq_start got=%h exp=0", pc); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++; if (pc !== 10'(i)) begin bad++; $display("FAIL seq_pc step=%0d got=%h exp=%h", i, pc, 10'(i)); end
        end
        total++; if (retiredCount !== 16'd5) begin bad++; $display("FAIL seq_count got=%0d exp=5", retiredCount); end
        // Undefined code advances like code 1.
        muxPC = 4'd11; tick();
        total++; if (pc !== 10'd6) begin bad++; $display("FAIL undef_code got=%h exp=6", pc); end
        $display("test_sequential done");
    endtask

    task automatic test_wrap_branch_jump();
        do_reset();
        muxPC = 4'd3; targetAddr = 10'h3FF; tick();
        total++; if (pc !== 10'h3FF) begin bad++; $display("FAIL jump_top got=%h exp=3ff", pc); end
        muxPC = 4'd1; tick();
        total++; if (pc !== 10'h000) begin bad++; $display("FAIL wrap got=%h exp=000", pc); end
        muxPC = 4'd2; branchTaken = 1'b0; targetAddr = 10'h020; tick();
        total++; if (pc !== 10'h001) begin bad++; $display("FAIL branch_not_taken got=%h exp=001", pc); end
        branchTaken = 1'b1; tick();
        total++; if (pc !== 10'h020) begin bad++; $display("FAIL branch_taken got=%h exp=020", pc); end
        muxPC = 4'd3; branchTaken = 1'b0; targetAddr = 10'h155; tick();
        total++; if (pc !== 10'h155) begin bad++; $display("FAIL jump got=%h exp=155", pc); end
        total++; if (retiredCount !== 16'd5) begin bad++; $display("FAIL bj_count got=%0d exp=5", retiredCount); end
        $display("test_wrap_branch_jump done");
    endtask

    task automatic test_wait_input();
        do_reset();
        muxPC = 4'd3; targetAddr = 10'd7; tick();
        muxPC = 4'd5; tick();
        total++; if (waitingInput !== 1'b1) begin bad++; $display("FAIL wait_enter got=%b exp=1", waitingInput); end
        total++; if (pc !== 10'd7) begin bad++; $display("FAIL wait_pc got=%h exp=7", pc); end
        for (int i = 0; i < 20; i++) begin
            muxPC = 4'($urandom_range(0, 15));
            targetAddr = 10'($urandom_range(0, 1023));
            branchTaken = 1'($urandom_range(0, 1));
            tick();
            total++; if (pc !== 10'd7 || waitingInput !== 1'b1 || inputCommit !== 1'b0) begin
                bad++; $display("FAIL wait_hold cyc=%0d pc=%h wait=%b commit=%b exp pc=7 wait=1 commit=0", i, pc, waitingInput, inputCommit);
            end
        end
        total++; if (retiredCount !== 16'd1) begin bad++; $display("FAIL wait_count_hold got=%0d exp=1", retiredCount); end
        inputConfirm = 1'b1;
        tick();
        total++; if (inputCommit !== 1'b0) begin bad++; $display("FAIL commit_early got=%b exp=0", inputCommit); end
        tick();
        total++; if (inputCommit !== 1'b1) begin bad++; $display("FAIL commit_pulse got=%b exp=1", inputCommit); end
        total++; if (pc !== 10'd7) begin bad++; $display("FAIL commit_pc_before got=%h exp=7", pc); end
        muxPC = 4'd4;
        tick();
        total++; if (inputCommit !== 1'b0) begin bad++; $display("FAIL commit_width got=%b exp=0", inputCommit); end
        total++; if (pc !== 10'd8) begin bad++; $display("FAIL commit_pc got=%h exp=8", pc); end
        total++; if (waitingInput !== 1'b0) begin bad++; $display("FAIL commit_exit got=%b exp=0", waitingInput); end
        total++; if (retiredCount !== 16'd2) begin bad++; $display("FAIL commit_count got=%0d exp=2", retiredCount); end
        inputConfirm = 1'b0;
        $display("test_wait_input done");
    endtask

    task automatic test_level_held();
        do_reset();
        muxPC = 4'd1; inputConfirm = 1'b1;
        repeat (4) tick();
        muxPC = 4'd5; tick();
        total++; if (pc !== 10'd4 || waitingInput !== 1'b1) begin bad++; $display("FAIL held_enter pc=%h wait=%b exp pc=4 wait=1", pc, waitingInput); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (inputCommit !== 1'b0 || pc !== 10'd4) begin bad++; $display("FAIL held_no_commit cyc=%0d commit=%b pc=%h exp 0/4", i, inputCommit, pc); end
        end
        inputConfirm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (inputCommit !== 1'b0 || waitingInput !== 1'b1) begin bad++; $display("FAIL held_low cyc=%0d commit=%b wait=%b exp 0/1", i, inputCommit, waitingInput); end
        end
        inputConfirm = 1'b1;
        tick(); tick();
        total++; if (inputCommit !== 1'b1) begin bad++; $display("FAIL held_fresh_commit got=%b exp=1", inputCommit); end
        muxPC = 4'd4; tick();
        total++; if (pc !== 10'd5 || waitingInput !== 1'b0) begin bad++; $display("FAIL held_exit pc=%h wait=%b exp pc=5 wait=0", pc, waitingInput); end
        inputConfirm = 1'b0;
        $display("test_level_held done");
    endtask

    task automatic test_halt();
        do_reset();
        muxPC = 4'd3; targetAddr = 10'h12; tick();
        muxPC = 4'd4; tick();
        total++; if (halted !== 1'b1 || pc !== 10'h12) begin bad++; $display("FAIL halt_enter halted=%b pc=%h exp 1/012", halted, pc); end
        total++; if (retiredCount !== 16'd1) begin bad++; $display("FAIL halt_count got=%0d exp=1", retiredCount); end
        muxPC = 4'd3; targetAddr = 10'h55;
        for (int i = 0; i < 50; i++) begin
            inputConfirm = ~inputConfirm;
            tick();
            total++; if (halted !== 1'b1 || pc !== 10'h12 || retiredCount !== 16'd1 || inputCommit !== 1'b0) begin
                bad++; $display("FAIL halt_hold cyc=%0d halted=%b pc=%h cnt=%0d commit=%b", i, halted, pc, retiredCount, inputCommit);
            end
        end
        #3;
        reset = 1'b0;
        #1;
        total++; if (pc !== 10'd0 || halted !== 1'b0) begin bad++; $display("FAIL halt_async_reset pc=%h halted=%b exp 000/0", pc, halted); end
        inputConfirm = 1'b0;
        tick();
        reset = 1'b1;
        $display("test_halt done");
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        muxPC = 4'd5; tick();
        inputConfirm = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        total++; if (waitingInput !== 1'b0 || inputCommit !== 1'b0 || pc !== 10'd0) begin
            bad++; $display("FAIL wait_abort wait=%b commit=%b pc=%h exp 0/0/000", waitingInput, inputCommit, pc);
        end
        tick();
        tick();
        total++; if (inputCommit !== 1'b0) begin bad++; $display("FAIL wait_abort_strobe got=%b exp=0", inputCommit); end
        inputConfirm = 1'b0;
        reset = 1'b1;
        $display("test_reset_in_wait done");
    endtask

    task automatic test_saturate();
        do_reset();
        muxPC = 4'd1;
        repeat (65534) tick();
        total++; if (retiredCount !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", retiredCount); end
        total++; if (pc !== 10'h3FE) begin bad++; $display("FAIL sat_pc got=%h exp=3fe", pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (retiredCount !== 16'hFFFF) begin bad++; $display("FAIL sat_hold step=%0d got=%h exp=ffff", i, retiredCount); end
        end
        total++; if (pc !== 10'h001) begin bad++; $display("FAIL sat_pc_after got=%h exp=001", pc); end
        $display("test_saturate done");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap_branch_jump();
        test_wait_input();
        test_level_held();
        test_halt();
        test_reset_in_wait();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
